// File: rtl/orbit_pixel_plotter_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by orbit_pixel_plotter.
//
// orbit_sample_if : valid/ready channel carrying one float27 (x, y) position
//                   sample from the orbital integrator.
//   in_valid  master->slave  sample present
//   in_ready  slave->master  consumer can take a sample
//   x, y      master->slave  float27: [26] sign, [25:18] exponent (bias 127),
//                            [17:0] mantissa with hidden leading 1
//
// orbit_fb_if     : req/ack framebuffer write port.
//   wr_req    master->slave  write request, held until wr_ack
//   wr_ack    slave->master  write accepted on the edge where both are high
//   wr_x      master->slave  column
//   wr_y      master->slave  row
//   wr_color  master->slave  8-bit colour
// -----------------------------------------------------------------------------

interface orbit_sample_if;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] x;
  logic [26:0] y;

  modport master (output in_valid, output x, output y, input in_ready);
  modport slave  (input in_valid, input x, input y, output in_ready);
endinterface

interface orbit_fb_if;
  logic       wr_req;
  logic       wr_ack;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [7:0] wr_color;

  modport master (output wr_req, output wr_x, output wr_y, output wr_color,
                  input wr_ack);
  modport slave  (input wr_req, input wr_x, input wr_y, input wr_color,
                  output wr_ack);
endinterface

// File: rtl/orbit_pixel_plotter.sv
// -----------------------------------------------------------------------------
// orbit_pixel_plotter
//
// Takes one float27 (x, y) position per handshake, converts it to integer
// screen coordinates and writes a pixel to the framebuffer. In the default
// build the previously drawn pixel is erased first, so one moving dot is
// shown. A draw counter and an off-screen flag are kept for software.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   smp         orbit_sample_if.slave  (in_valid / in_ready / x / y)
//   fb          orbit_fb_if.master     (wr_req / wr_ack / wr_x / wr_y / wr_color)
//   busy        state machine is not in IDLE
//   off_screen  last accepted sample mapped outside the visible area
//   plot_count  completed draws, wraps 16'hFFFF -> 0
//
// Build option:
//   PLOT_TRAIL_EN  when defined the erase step is skipped and every on-screen
//                  sample leaves a persistent pixel (orbit trail). The previous
//                  pixel is still tracked.
//
// Flow: IDLE -> CONVERT (1 cycle) -> [ERASE] -> [DRAW] -> IDLE.
// Write outputs are decoded from the state and registers that do not change
// while a request is pending, so they are stable for the whole request.
// -----------------------------------------------------------------------------

module orbit_pixel_plotter #(
  parameter int         WIDTH       = 640,
  parameter int         HEIGHT      = 480,
  parameter int         CX          = 320,
  parameter int         CY          = 240,
  parameter int         SCALE_SHIFT = 10,
  parameter logic [7:0] ORBIT_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  orbit_sample_if.slave         smp,
  orbit_fb_if.master            fb,
  output logic                  busy,
  output logic                  off_screen,
  output logic [15:0]           plot_count
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ERASE,
    DRAW
  } state_t;

  // Decoded axis: in_range is low when the exponent is too large to
  // represent; pos is the scaled, signed pixel offset from the origin.
  typedef struct packed {
    logic               in_range;
    logic signed [25:0] pos;
  } axis_t;

  // Screen geometry as 27-bit signed values so the mapping arithmetic can go
  // negative or past the edge without wrapping.
  localparam logic signed [26:0] CX_S = 27'(CX);
  localparam logic signed [26:0] CY_S = 27'(CY);
  localparam logic signed [26:0] W_S  = 27'(WIDTH);
  localparam logic signed [26:0] H_S  = 27'(HEIGHT);

  // float27 -> signed scaled pixel offset.
  // Magnitude is floor(1.mant * 2^(e-127)), truncated toward zero; values
  // below 1.0 give 0, exponents beyond 2^23 are flagged out of range.
  function automatic axis_t decode_axis(input logic [26:0] f);
    axis_t       r;
    logic [7:0]  e;
    logic [23:0] mag;
    logic [23:0] scaled;
    e          = f[25:18];
    r.in_range = 1'b1;
    mag        = '0;
    if (e > 8'd150) begin
      r.in_range = 1'b0;
    end else if (e >= 8'd127) begin
      // {1,mant} is the significand scaled by 2^18; shift by the unbiased
      // exponent, then drop the 18 fraction bits.
      mag = 24'(({23'd0, 1'b1, f[17:0]} << (e - 8'd127)) >> 18);
    end
    scaled = mag >> SCALE_SHIFT;
    r.pos  = f[26] ? -$signed({2'b00, scaled}) : $signed({2'b00, scaled});
    return r;
  endfunction

  state_t             state;
  state_t             state_n;

  logic [26:0]        x_q;
  logic [26:0]        y_q;
  logic [9:0]         sx_q;
  logic [9:0]         sy_q;
  logic               on_q;
  logic [9:0]         prev_x;
  logic [9:0]         prev_y;
  logic               held;

  axis_t              ax;
  axis_t              ay;
  logic signed [26:0] sx_c;
  logic signed [26:0] sy_c;
  logic               on_c;

  logic               ready;
  logic               accept;
  logic               wr_req;
  logic [9:0]         wr_x;
  logic [9:0]         wr_y;
  logic [7:0]         wr_color;

  // Ready is forced low while reset is held and rises as soon as it releases.
  assign ready  = rst && (state == IDLE);
  assign accept = smp.in_valid && ready;
  assign busy   = (state != IDLE);

  // Screen mapping of the captured sample; y axis points up on screen.
  always_comb begin
    ax   = decode_axis(x_q);
    ay   = decode_axis(y_q);
    sx_c = CX_S + $signed({ax.pos[25], ax.pos});
    sy_c = CY_S - $signed({ay.pos[25], ay.pos});
    on_c = ax.in_range && ay.in_range &&
           !sx_c[26] && (sx_c < W_S) &&
           !sy_c[26] && (sy_c < H_S);
  end

  // Next state and write-port outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state;
    wr_req   = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_color = '0;
    case (state)
      IDLE: begin
        if (accept) state_n = CONVERT;
      end
      CONVERT: begin
`ifdef PLOT_TRAIL_EN
        state_n = on_c ? DRAW : IDLE;
`else
        if (held)      state_n = ERASE;
        else if (on_c) state_n = DRAW;
        else           state_n = IDLE;
`endif
      end
      ERASE: begin
        wr_req   = 1'b1;
        wr_x     = prev_x;
        wr_y     = prev_y;
        wr_color = BG_COLOR;
        if (fb.wr_ack) state_n = on_q ? DRAW : IDLE;
      end
      DRAW: begin
        wr_req   = 1'b1;
        wr_x     = sx_q;
        wr_y     = sy_q;
        wr_color = ORBIT_COLOR;
        if (fb.wr_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the datapath registers are reset too; the write port and the
    // held pixel must read zero and be forgotten after any reset.
    if (!rst) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      on_q       <= 1'b0;
      prev_x     <= '0;
      prev_y     <= '0;
      held       <= 1'b0;
      off_screen <= 1'b0;
      plot_count <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            x_q <= smp.x;
            y_q <= smp.y;
          end
        end
        CONVERT: begin
          sx_q       <= sx_c[9:0];
          sy_q       <= sy_c[9:0];
          on_q       <= on_c;
          off_screen <= !on_c;
        end
        ERASE: begin
          if (fb.wr_ack) held <= 1'b0;
        end
        DRAW: begin
          if (fb.wr_ack) begin
            prev_x     <= sx_q;
            prev_y     <= sy_q;
            held       <= 1'b1;
            plot_count <= plot_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign smp.in_ready = ready;
  assign fb.wr_req    = wr_req;
  assign fb.wr_x      = wr_x;
  assign fb.wr_y      = wr_y;
  assign fb.wr_color  = wr_color;

  // A pending write keeps its request and payload until acknowledged.
  a_wr_hold: assert property (@(posedge clk) disable iff (!rst)
    (fb.wr_req && !fb.wr_ack) |=>
      (fb.wr_req && $stable({fb.wr_x, fb.wr_y, fb.wr_color})));

  // No sample is offered acceptance while a conversion or write is running.
  a_busy_not_ready: assert property (@(posedge clk) disable iff (!rst)
    busy |-> !smp.in_ready);

endmodule

// File: tb/tb_orbit_pixel_plotter.sv
module tb_orbit_pixel_plotter;

`ifdef PLOT_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  // float27 stimulus constants with hand-derived screen positions
  localparam logic [26:0] F_ZERO  = 27'h0000000;                 // 0
  localparam logic [26:0] F_P100K = 27'h23E1A80;                 // +100000 -> +97 px
  localparam logic [26:0] F_N100K = 27'h63E1A80;                 // -100000 -> -97 px
  localparam logic [26:0] F_2P20  = 27'h24C0000;                 // 2^20 -> 1024 px
  localparam logic [26:0] F_BIG   = {1'b0, 8'd151, 18'd0};       // 2^24, out of range
  localparam logic [26:0] F_X639  = {1'b0, 8'd145, 18'd64512};   // 326656 -> 319 px
  localparam logic [26:0] F_X640  = {1'b0, 8'd145, 18'd65536};   // 327680 -> 320 px
  localparam logic [26:0] F_Y0    = {1'b0, 8'd144, 18'd229376};  // 245760 -> 240 px
  localparam logic [26:0] F_SMALL = {1'b1, 8'd126, 18'h3FFFF};   // -0.99.. -> 0 px

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        off_screen;
  logic [15:0] plot_count;

  orbit_sample_if sif ();
  orbit_fb_if     fb ();

  orbit_pixel_plotter dut (
    .clk        (clk),
    .rst        (rst),
    .smp        (sif),
    .fb         (fb),
    .busy       (busy),
    .off_screen (off_screen),
    .plot_count (plot_count)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  // protocol-level expectation state
  bit         held_m = 1'b0;
  logic [9:0] prev_xm = '0;
  logic [9:0] prev_ym = '0;
  int         count_m = 0;

  int ack_delay = 0;
  bit force_ack = 1'b0;

  logic [9:0] hold_x;
  logic [9:0] hold_y;
  logic [7:0] hold_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push the writes a sample should produce, given pixel (ex, ey).
  task automatic expect_sample(input bit on, input int ex, input int ey);
    if (!TRAIL && held_m) begin
      exp_q.push_back('{prev_xm, prev_ym, 8'h00});
      held_m = 1'b0;
    end
    if (on) begin
      exp_q.push_back('{10'(ex), 10'(ey), 8'hFF});
      prev_xm = 10'(ex);
      prev_ym = 10'(ey);
      held_m  = 1'b1;
      count_m++;
    end
  endtask

  // Offer one sample; returns just after the accepting edge.
  task automatic send(input logic [26:0] xv, input logic [26:0] yv);
    int g = 0;
    @(negedge clk);
    while (!sif.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_timeout", 32'(g < 50), 32'd1);
    sif.x        = xv;
    sif.y        = yv;
    sif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("busy_timeout", 32'(g < 50), 32'd1);
  endtask

  // Framebuffer acknowledge model: ack after ack_delay request cycles.
  initial begin
    int cnt = 0;
    bit xfer;
    fb.wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      xfer = fb.wr_req && fb.wr_ack;
      @(posedge clk);
      #1;
      if (xfer || !fb.wr_req) cnt = 0;
      if (fb.wr_req) begin
        fb.wr_ack = (cnt >= ack_delay);
        cnt++;
      end else begin
        fb.wr_ack = force_ack;
      end
    end
  end

  // Scoreboard: a write completes on the next edge when req and ack are high.
  always @(negedge clk) begin
    if (rst && fb.wr_req && fb.wr_ack) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed (%0d,%0d,0x%0h), expected no write",
               fb.wr_x, fb.wr_y, fb.wr_color);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_x", 32'(fb.wr_x), 32'(mon_e.x));
        check("wr_y", 32'(fb.wr_y), 32'(mon_e.y));
        check("wr_color", 32'(fb.wr_color), 32'(mon_e.c));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    sif.in_valid = 1'b0;
    sif.x        = '0;
    sif.y        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(sif.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_req", 32'(fb.wr_req), 32'd0);
    check("rst_wr_xyc", 32'({fb.wr_x, fb.wr_y, fb.wr_color}), 32'd0);
    check("rst_plot_count", 32'(plot_count), 32'd0);
    check("rst_off_screen", 32'(off_screen), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(sif.in_ready), 32'd1);

    // first sample: draw only, check cycle timing
    expect_sample(1'b1, 417, 240);
    send(F_P100K, F_ZERO);
    @(negedge clk);
    check("s1_c1_busy", 32'(busy), 32'd1);
    check("s1_c1_wr_req", 32'(fb.wr_req), 32'd0);
    @(negedge clk);
    check("s1_c2_wr_req", 32'(fb.wr_req), 32'd1);
    check("s1_c2_color", 32'(fb.wr_color), 32'hFF);
    @(negedge clk);
    check("s1_c3_in_ready", 32'(sif.in_ready), 32'd1);
    check("s1_plot_count", 32'(plot_count), 32'(count_m));
    check("s1_off_screen", 32'(off_screen), 32'd0);

    // second sample: erase then draw
    expect_sample(1'b1, 223, 240);
    send(F_N100K, F_ZERO);
`ifndef PLOT_TRAIL_EN
    @(negedge clk);
    check("s2_c1_wr_req", 32'(fb.wr_req), 32'd0);
    @(negedge clk);
    check("s2_c2_erase_color", 32'(fb.wr_color), 32'h00);
    check("s2_c2_erase_x", 32'(fb.wr_x), 32'd417);
    @(negedge clk);
    check("s2_c3_draw_color", 32'(fb.wr_color), 32'hFF);
    check("s2_c3_in_ready", 32'(sif.in_ready), 32'd0);
    @(negedge clk);
    check("s2_c4_in_ready", 32'(sif.in_ready), 32'd1);
`else
    wait_idle();
`endif
    check("s2_plot_count", 32'(plot_count), 32'(count_m));
    check("s2_off_screen", 32'(off_screen), 32'd0);

    // off-screen sample: erase only, count unchanged
    expect_sample(1'b0, 0, 0);
    send(F_2P20, F_ZERO);
    wait_idle();
    check("s3_off_screen", 32'(off_screen), 32'd1);
    check("s3_plot_count", 32'(plot_count), 32'(count_m));

    // held pixel was cleared by that erase: draw only
    expect_sample(1'b1, 417, 143);
    send(F_P100K, F_P100K);
    wait_idle();
    check("s4_off_screen", 32'(off_screen), 32'd0);
    check("s4_plot_count", 32'(plot_count), 32'(count_m));

    // acknowledge delayed by 5 cycles: request and payload held
`ifdef PLOT_TRAIL_EN
    hold_x = 10'd320; hold_y = 10'd337; hold_c = 8'hFF;
`else
    hold_x = 10'd417; hold_y = 10'd143; hold_c = 8'h00;
`endif
    ack_delay = 5;
    expect_sample(1'b1, 320, 337);
    send(F_ZERO, F_N100K);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_wr_req", 32'(fb.wr_req), 32'd1);
      check("hold_wr_x", 32'(fb.wr_x), 32'(hold_x));
      check("hold_wr_y", 32'(fb.wr_y), 32'(hold_y));
      check("hold_wr_color", 32'(fb.wr_color), 32'(hold_c));
      check("hold_in_ready", 32'(sif.in_ready), 32'd0);
    end
    wait_idle();
    ack_delay = 0;
    check("s5_plot_count", 32'(plot_count), 32'(count_m));

    // exponent beyond 2^23: out of range
    expect_sample(1'b0, 0, 0);
    send(F_BIG, F_ZERO);
    wait_idle();
    check("s6_off_screen", 32'(off_screen), 32'd1);
    check("s6_plot_count", 32'(plot_count), 32'(count_m));

    // right edge: column 639 visible, 640 not
    expect_sample(1'b1, 639, 240);
    send(F_X639, F_ZERO);
    wait_idle();
    check("x639_off_screen", 32'(off_screen), 32'd0);
    expect_sample(1'b0, 0, 0);
    send(F_X640, F_ZERO);
    wait_idle();
    check("x640_off_screen", 32'(off_screen), 32'd1);

    // top edge row 0, then a sub-unity negative value maps to the origin
    expect_sample(1'b1, 320, 0);
    send(F_ZERO, F_Y0);
    wait_idle();
    check("y0_off_screen", 32'(off_screen), 32'd0);
    expect_sample(1'b1, 320, 240);
    send(F_SMALL, F_ZERO);
    wait_idle();
    check("small_off_screen", 32'(off_screen), 32'd0);
    check("s9_plot_count", 32'(plot_count), 32'(count_m));

    // acknowledge with no request pending is ignored
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_plot_count", 32'(plot_count), 32'(count_m));
    force_ack = 1'b0;
    @(negedge clk);

    // reset while a write is pending
    ack_delay = 5;
    send(F_P100K, F_ZERO);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_wr_req", 32'(fb.wr_req), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    held_m  = 1'b0;
    count_m = 0;
    @(negedge clk);
    check("mid_rst_wr_req", 32'(fb.wr_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_plot_count", 32'(plot_count), 32'd0);
    check("mid_rst_in_ready", 32'(sif.in_ready), 32'd0);
    check("mid_rst_wr_xyc", 32'({fb.wr_x, fb.wr_y, fb.wr_color}), 32'd0);
    ack_delay = 0;
    @(posedge clk);
    #1 rst = 1'b1;

    // first sample after reset draws with no erase
    expect_sample(1'b1, 223, 240);
    send(F_N100K, F_ZERO);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_color", 32'(fb.wr_color), 32'hFF);
    check("post_rst_wr_x", 32'(fb.wr_x), 32'd223);
    wait_idle();
    check("post_rst_plot_count", 32'(plot_count), 32'(count_m));

    @(negedge clk);
    check("leftover_writes", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
